reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- Circular in-order Reorder Buffer.
- Accepts allocations from the Dispatcher and result write-backs from the Reservation Station and LSB.
- Exposes operand lookup so the Dispatcher can resolve Qj/Qk.
- Retires one entry per cycle in program order: register-file write, store release, or branch/jalr resolution. On a misprediction it raises the global flush_signal and a redirect PC.

Parameters:
- RoB_WIDTH, 4, index width.
- RoB_SIZE, 1<<RoB_WIDTH, entry count.
- NON_DEP, 1<<RoB_WIDTH, "no dependency" tag value.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous active-high reset.
- rdy_in  in  1  global enable; low = pause.
- alloc_en  in  1  Dispatcher allocates an entry this cycle.
- alloc_type  in  2  0=reg write, 1=branch, 2=jalr, 3=store.
- alloc_rd  in  5  destination register (ignored for types 1 and 3).
- alloc_pc  in  32  instruction PC.
- alloc_pred_taken  in  1  predicted direction (branch only).
- alloc_pred_target  in  32  predicted target (branch taken target / jalr target).
- alloc_index  out  RoB_WIDTH  tail index the next allocation receives.
- isFull  out  1  count==RoB_SIZE.
- isEmpty  out  1  count==0.
- wb_en  in  1  result write-back (RS RoB_update_*).
- wb_index  in  RoB_WIDTH  write-back entry.
- wb_data  in  32  result (branch: bit0 = taken).
- query_j_index  in  RoB_WIDTH+1  operand tag j.
- query_j_ready  out  1  tag j value available.
- query_j_data  out  32  tag j value.
- query_k_index  in  RoB_WIDTH+1  operand tag k.
- query_k_ready  out  1  tag k value available.
- query_k_data  out  32  tag k value.
- commit_en  out  1  reg-write commit pulse.
- commit_rd  out  5  destination register.
- commit_data  out  32  value to write.
- commit_index  out  RoB_WIDTH  retiring entry, for regfile tag clear.
- store_commit_en  out  1  store at head may write memory.
- store_commit_index  out  RoB_WIDTH  that store's entry.
- flush_signal  out  1  misprediction flush pulse.
- redirect_pc  out  32  correct fetch PC.

Behaviour:
- Reset (async, rst_in high):
  - head=tail=count=0; all valid/ready bits 0.
  - Every output register is 0: commit_*, store_commit_*, flush_signal, redirect_pc.
- Pause (rdy_in low): all state and registered outputs hold.
- Allocation:
  - If alloc_en && !isFull, the entry at tail is written with valid=1, ready=0; tail <= tail+1 (mod RoB_SIZE, wraps 15->0); count++.
  - alloc_en while isFull is ignored; the Dispatcher must not assert it.
  - alloc_index = tail, combinational.
- Write-back: if wb_en, entry wb_index gets data<=wb_data, ready<=1. Write-back to an invalid entry is ignored.
- Query (combinational), for each of j/k:
  - Index==NON_DEP: ready=0, data=0.
  - Else wb_en && wb_index matches: ready=1, data=wb_data (bypass).
  - Else valid&&ready entry: ready=1, data=stored data.
  - Else ready=0.
- Commit:
  - Each cycle, if the head entry is valid&&ready (registered state; a same-cycle write-back commits next cycle), retire it: head++, count--. Outputs are registered, so they are visible one cycle after ready is set.
  - Every pulse output (commit_en, store_commit_en, flush_signal) defaults to 0 each cycle.
  - Type 0: commit_en=1 with rd/data/index. rd==0 still pulses; the regfile ignores x0.
  - Type 3: store_commit_en=1, store_commit_index=head.
  - Type 1: taken=data[0]. If taken!=pred_taken: flush_signal=1; redirect_pc = taken ? pred_target : pc+4.
  - Type 2: commit_en=1 with data=pc+4. If data!=pred_target: flush_signal=1; redirect_pc=data.
    - Because data is overwritten with pc+4, the jalr target is kept in a separate per-entry field captured at write-back.
- Same-cycle allocation and commit: count unchanged, both pointers advance. isFull uses the registered count, so a commit does not free space the same cycle.
- Flush (registered, the cycle after the mispredicting commit is emitted):
  - All valid/ready bits clear; head=tail=count=0.
  - Any alloc_en/wb_en in that cycle is ignored.
  - The mispredicting entry's own commit_en (jalr) is still emitted.

Test Plan:
- Reset, then alloc 3 type-0 entries (rd=1,2,3) -> alloc_index 0,1,2; isEmpty=0; no commit.
- wb idx1=0x22, then idx0=0x11 -> commits in order: rd1=0x11 index0, then rd2=0x22 index1, on consecutive cycles.
- Fill 16 entries -> isFull=1; a 17th alloc is ignored. Commit one, then alloc -> tail wraps to 0 and alloc_index=0.
- query_j_index=5 with wb_en idx5=0xABCD the same cycle -> query_j_ready=1, data=0xABCD. query_k_index=16 -> ready=0.
- Branch pc=0x100, pred_taken=0, target=0x180, wb data=1 -> flush_signal=1, redirect_pc=0x180; next cycle isEmpty=1, head=tail=0.
- jalr pc=0x40, pred_target=0x200, wb target=0x200 -> commit_en with data 0x44, no flush. A repeat with wb 0x300 -> flush with redirect_pc=0x300.

Source files
------------

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer with operand lookup, retirement and flush
// Entries retire one per cycle from head; a mispredicting retirement flushes the whole buffer one cycle later.
module reorder_buffer #(
  parameter int RoB_WIDTH = 4,
  parameter int RoB_SIZE  = 1 << RoB_WIDTH,
  parameter int NON_DEP   = 1 << RoB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 alloc_en,
  input  logic [1:0]           alloc_type,
  input  logic [4:0]           alloc_rd,
  input  logic [31:0]          alloc_pc,
  input  logic                 alloc_pred_taken,
  input  logic [31:0]          alloc_pred_target,
  output logic [RoB_WIDTH-1:0] alloc_index,
  output logic                 isFull,
  output logic                 isEmpty,
  input  logic                 wb_en,
  input  logic [RoB_WIDTH-1:0] wb_index,
  input  logic [31:0]          wb_data,
  input  logic [RoB_WIDTH:0]   query_j_index,
  output logic                 query_j_ready,
  output logic [31:0]          query_j_data,
  input  logic [RoB_WIDTH:0]   query_k_index,
  output logic                 query_k_ready,
  output logic [31:0]          query_k_data,
  output logic                 commit_en,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_data,
  output logic [RoB_WIDTH-1:0] commit_index,
  output logic                 store_commit_en,
  output logic [RoB_WIDTH-1:0] store_commit_index,
  output logic                 flush_signal,
  output logic [31:0]          redirect_pc
);

  localparam logic [1:0] TYPE_REG  = 2'd0;
  localparam logic [1:0] TYPE_BR   = 2'd1;
  localparam logic [1:0] TYPE_JALR = 2'd2;
  localparam logic [1:0] TYPE_ST   = 2'd3;
  localparam logic [RoB_WIDTH:0] NO_DEP_TAG = (RoB_WIDTH + 1)'(NON_DEP);
  localparam logic [RoB_WIDTH:0] FULL_COUNT = (RoB_WIDTH + 1)'(RoB_SIZE);

  logic [RoB_WIDTH-1:0] head;
  logic [RoB_WIDTH-1:0] tail;
  logic [RoB_WIDTH:0]   count;

  logic [RoB_SIZE-1:0] ent_valid;
  logic [RoB_SIZE-1:0] ent_ready;
  logic [RoB_SIZE-1:0] ent_pred_taken;
  logic [1:0]          ent_type        [RoB_SIZE];
  logic [4:0]          ent_rd          [RoB_SIZE];
  logic [31:0]         ent_pc          [RoB_SIZE];
  logic [31:0]         ent_pred_target [RoB_SIZE];
  logic [31:0]         ent_data        [RoB_SIZE];
  logic [31:0]         ent_target      [RoB_SIZE];

  logic        running;
  logic        do_alloc;
  logic        do_commit;
  logic        wb_hit;
  logic        head_taken;
  logic        head_mispredict;
  logic [31:0] head_link;
  logic [31:0] head_redirect;

  assign alloc_index = tail;
  assign isFull      = (count == FULL_COUNT);
  assign isEmpty     = (count == '0);

  // A pending flush owns the cycle: nothing else is allowed to touch the buffer.
  assign running   = rdy_in && !flush_signal;
  assign do_alloc  = running && alloc_en && !isFull;
  assign wb_hit    = running && wb_en && ent_valid[wb_index];
  assign do_commit = running && ent_valid[head] && ent_ready[head];

  always_comb begin
    head_link       = ent_pc[head] + 32'd4;
    head_taken      = ent_data[head][0];
    head_mispredict = 1'b0;
    head_redirect   = 32'd0;
    case (ent_type[head])
      TYPE_BR: begin
        head_mispredict = (head_taken != ent_pred_taken[head]);
        head_redirect   = head_taken ? ent_pred_target[head] : head_link;
      end
      TYPE_JALR: begin
        head_mispredict = (ent_target[head] != ent_pred_target[head]);
        head_redirect   = ent_target[head];
      end
      default: ;
    endcase
  end

  always_comb begin
    query_j_ready = 1'b0;
    query_j_data  = 32'd0;
    if (query_j_index == NO_DEP_TAG) begin
      query_j_ready = 1'b0;
    end else if (wb_en && wb_index == query_j_index[RoB_WIDTH-1:0]) begin
      query_j_ready = 1'b1;
      query_j_data  = wb_data;
    end else if (ent_valid[query_j_index[RoB_WIDTH-1:0]] && ent_ready[query_j_index[RoB_WIDTH-1:0]]) begin
      query_j_ready = 1'b1;
      query_j_data  = ent_data[query_j_index[RoB_WIDTH-1:0]];
    end
  end

  always_comb begin
    query_k_ready = 1'b0;
    query_k_data  = 32'd0;
    if (query_k_index == NO_DEP_TAG) begin
      query_k_ready = 1'b0;
    end else if (wb_en && wb_index == query_k_index[RoB_WIDTH-1:0]) begin
      query_k_ready = 1'b1;
      query_k_data  = wb_data;
    end else if (ent_valid[query_k_index[RoB_WIDTH-1:0]] && ent_ready[query_k_index[RoB_WIDTH-1:0]]) begin
      query_k_ready = 1'b1;
      query_k_data  = ent_data[query_k_index[RoB_WIDTH-1:0]];
    end
  end

  // Payload needs no reset: it is only observed through valid/ready.
  always_ff @(posedge clk_in) begin
    if (do_alloc) begin
      ent_type[tail]        <= alloc_type;
      ent_rd[tail]          <= alloc_rd;
      ent_pc[tail]          <= alloc_pc;
      ent_pred_taken[tail]  <= alloc_pred_taken;
      ent_pred_target[tail] <= alloc_pred_target;
    end
    if (wb_hit) begin
      ent_data[wb_index]   <= (ent_type[wb_index] == TYPE_JALR) ? ent_pc[wb_index] + 32'd4 : wb_data;
      ent_target[wb_index] <= wb_data;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      ent_valid          <= '0;
      ent_ready          <= '0;
      commit_en          <= 1'b0;
      commit_rd          <= 5'd0;
      commit_data        <= 32'd0;
      commit_index       <= '0;
      store_commit_en    <= 1'b0;
      store_commit_index <= '0;
      flush_signal       <= 1'b0;
      redirect_pc        <= 32'd0;
    end else if (rdy_in) begin
      commit_en       <= 1'b0;
      store_commit_en <= 1'b0;
      flush_signal    <= 1'b0;
      if (flush_signal) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        ent_valid <= '0;
        ent_ready <= '0;
      end else begin
        if (wb_hit) begin
          ent_ready[wb_index] <= 1'b1;
        end
        if (do_alloc) begin
          ent_valid[tail] <= 1'b1;
          ent_ready[tail] <= 1'b0;
          tail            <= tail + 1'b1;
        end
        if (do_commit) begin
          ent_valid[head] <= 1'b0;
          ent_ready[head] <= 1'b0;
          head            <= head + 1'b1;
          case (ent_type[head])
            TYPE_REG, TYPE_JALR: begin
              // jalr data already holds the link value pc+4
              commit_en    <= 1'b1;
              commit_rd    <= ent_rd[head];
              commit_data  <= ent_data[head];
              commit_index <= head;
            end
            TYPE_ST: begin
              store_commit_en    <= 1'b1;
              store_commit_index <= head;
            end
            default: ;
          endcase
          if (head_mispredict) begin
            flush_signal <= 1'b1;
            redirect_pc  <= head_redirect;
          end
        end
        case ({do_alloc, do_commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
